// File: rtl/defs_pkg.sv
// Shared types for the unified instruction/data memory arbiter of the 16-bit multicycle CPU.
package defs_pkg;
  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } arb_owner_t;

  // Sized to the CPU's 16-bit memory word and address.
  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access.
module mem_arbiter
  import defs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  arb_owner_t       r_owner;
  arb_owner_t       r_last_owner;
  arb_owner_t       w_winner;
  mem_req_t         r_req;
  mem_req_t         w_pick;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any_req;

  assign w_any_req = if_req | d_req;

  // On a tie the requester not served last wins; a lone request always wins.
  assign w_winner = (if_req && d_req) ?
                    ((r_last_owner == OWNER_IF) ? OWNER_D : OWNER_IF) :
                    (d_req ? OWNER_D : OWNER_IF);

  always_comb begin
    w_pick = '0;
    if (w_winner == OWNER_D) begin
      w_pick.we    = d_we;
      w_pick.addr  = REQ_ADDR_W'(d_addr);
      w_pick.wdata = REQ_DATA_W'(d_wdata);
    end else begin
      w_pick.addr  = REQ_ADDR_W'(if_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWNER_IF;
      r_last_owner <= OWNER_IF;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB_IDLE && w_any_req) begin
        r_owner <= w_winner;
        r_req   <= w_pick;
      end
      if (r_state == ARB_ISSUE) begin
        r_last_owner <= r_owner;
        r_cnt        <= CNT_LOAD;
      end else if (r_state == ARB_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    d_rvalid     = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) w_next_state = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = r_req.we;
        mem_addr  = ADDR_WIDTH'(r_req.addr);
        mem_wdata = DATA_WIDTH'(r_req.wdata);
        if_gnt    = (r_owner == OWNER_IF);
        d_gnt     = (r_owner == OWNER_D);
        // Stores complete at issue; reads wait out the memory latency.
        if (r_req.we)              w_next_state = ARB_IDLE;
        else if (MEM_LATENCY == 1) w_next_state = ARB_RESP;
        else                       w_next_state = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (r_cnt == '0) w_next_state = ARB_RESP;
      end
      ARB_RESP: begin
        if_rvalid    = (r_owner == OWNER_IF);
        d_rvalid     = (r_owner == OWNER_D);
        w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at memory latencies 1 and 3 against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct { int cyc; bit own_d; bit we; logic [15:0] addr; logic [15:0] wdata; } gexp_t;
  typedef struct { int cyc; bit own_d; logic [15:0] data; } rexp_t;
  typedef struct { int delay; bit we; logic [15:0] addr; logic [15:0] wdata; } item_t;

  // Power-up memory contents; 0x0010 holds the known fetch word.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    return (a * 16'd2654) ^ 16'h5A3C;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : 3;

    logic        resetn, if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, mem_en, mem_we;
    logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        rst_q;
    logic [15:0] ram    [0:511];
    logic        ram_wr [0:511];
    logic [15:0] rpipe  [0:L-1];

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(L)) u_dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory macro: fixed read latency L from the mem_en cycle.
    function automatic logic [15:0] ram_rd(input logic [15:0] a);
      if (ram_wr[a[8:0]] === 1'b1) return ram[a[8:0]];
      return init_val(a);
    endfunction

    assign mem_rdata = rpipe[L-1];
    always @(posedge clk) begin
      rst_q <= resetn;
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        ram[mem_addr[8:0]]    <= mem_wdata;
        ram_wr[mem_addr[8:0]] <= 1'b1;
      end
      rpipe[0] <= (mem_en === 1'b1 && mem_we === 1'b0) ? ram_rd(mem_addr) : 16'hDEAD;
      for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
    end

    // Reference model state
    gexp_t       gq[$];
    rexp_t       rq[$];
    item_t       iq_if[$];
    item_t       iq_d[$];
    item_t       cur[2];
    int          ast[2];        // 0 free, 1 delaying, 2 requesting, 3 holding through gnt
    int          hold_until[2];
    logic [15:0] mmem [int];
    int          cyc = 0;
    int          mcyc = 0;
    int          next_arb = -1;
    bit          last_d = 1'b0;
    int          rst_left = 0;
    bit          olog[$];

    function automatic logic [15:0] mread(input logic [15:0] a);
      if (mmem.exists(int'(a))) return mmem[int'(a)];
      return init_val(a);
    endfunction

    task automatic drive(input int a, input bit on);
      if (a == 0) begin
        if_req  = on;
        if_addr = on ? cur[0].addr : 16'($urandom);
      end else begin
        d_req   = on;
        d_we    = on ? cur[1].we : 1'($urandom);
        d_addr  = on ? cur[1].addr : 16'($urandom);
        d_wdata = on ? cur[1].wdata : 16'($urandom);
      end
    endtask

    task automatic step();
      int w;
      @(negedge clk);
      cyc++;
      if (rst_left > 0) begin
        rst_left--;
        resetn = 1'b0;
        while (gq.size() > 0 && gq[gq.size()-1].cyc > cyc) gq.delete(gq.size()-1);
        while (rq.size() > 0 && rq[rq.size()-1].cyc > cyc) rq.delete(rq.size()-1);
        ast[0] = 0; ast[1] = 0;
        drive(0, 1'b0); drive(1, 1'b0);
        last_d   = 1'b0;
        next_arb = -1;
        return;
      end
      if (resetn !== 1'b1) next_arb = cyc;
      resetn = 1'b1;
      for (int a = 0; a < 2; a++) begin
        if (ast[a] == 3 && cyc > hold_until[a]) begin
          ast[a] = 0;
          drive(a, 1'b0);
        end
        if (ast[a] == 0) begin
          if (a == 0 && iq_if.size() > 0) begin cur[0] = iq_if.pop_front(); ast[0] = 1; end
          if (a == 1 && iq_d.size() > 0)  begin cur[1] = iq_d.pop_front();  ast[1] = 1; end
        end
        if (ast[a] == 1) begin
          if (cur[a].delay == 0) begin ast[a] = 2; drive(a, 1'b1); end
          else cur[a].delay--;
        end
      end
      if (cyc == next_arb) begin
        if (ast[0] == 2 || ast[1] == 2) begin
          w = (ast[0] == 2 && ast[1] == 2) ? (last_d ? 0 : 1) : ((ast[1] == 2) ? 1 : 0);
          last_d = (w == 1);
          gq.push_back('{cyc + 1, w == 1, cur[w].we, cur[w].addr, cur[w].wdata});
          if (cur[w].we) begin
            mmem[int'(cur[w].addr)] = cur[w].wdata;
            next_arb = cyc + 2;
          end else begin
            rq.push_back('{cyc + 1 + L, w == 1, mread(cur[w].addr)});
            next_arb = cyc + 2 + L;
          end
          ast[w]        = 3;
          hold_until[w] = cyc + 1;
        end else begin
          next_arb = cyc + 1;
        end
      end
    endtask

    task automatic wait_idle(input int bound, input string nm);
      int n = 0;
      while ((gq.size() > 0 || rq.size() > 0 || iq_if.size() > 0 || iq_d.size() > 0 ||
              ast[0] != 0 || ast[1] != 0) && n < bound) begin
        step();
        n++;
      end
      chk(n < bound, $sformatf("L%0d_%s_timeout", L, nm), n, bound);
    endtask

    // Monitor: pops the scoreboard whenever the DUT is due to show a grant or response.
    gexp_t ge;
    rexp_t re;
    always @(negedge clk) begin
      mcyc++;
      if (rst_q !== 1'b1) begin
        chk({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} == 6'b0,
            $sformatf("L%0d_reset_ctrl", L), {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}, 0);
        chk(mem_addr == 16'h0 && mem_wdata == 16'h0, $sformatf("L%0d_reset_bus", L), {mem_addr, mem_wdata}, 0);
      end else begin
        if (gq.size() > 0 && gq[0].cyc == mcyc) begin
          ge = gq.pop_front();
          chk(if_gnt == !ge.own_d && d_gnt == ge.own_d && mem_en == 1'b1 && mem_we == ge.we,
              $sformatf("L%0d_grant", L), {if_gnt, d_gnt, mem_en, mem_we}, {!ge.own_d, ge.own_d, 1'b1, ge.we});
          chk(mem_addr == ge.addr, $sformatf("L%0d_mem_addr", L), mem_addr, ge.addr);
          if (ge.we) chk(mem_wdata == ge.wdata, $sformatf("L%0d_mem_wdata", L), mem_wdata, ge.wdata);
          olog.push_back(d_gnt);
        end else begin
          chk({if_gnt, d_gnt, mem_en, mem_we} == 4'b0, $sformatf("L%0d_no_grant", L),
              {if_gnt, d_gnt, mem_en, mem_we}, 0);
        end
        if (rq.size() > 0 && rq[0].cyc == mcyc) begin
          re = rq.pop_front();
          chk(if_rvalid == !re.own_d && d_rvalid == re.own_d, $sformatf("L%0d_rvalid", L),
              {if_rvalid, d_rvalid}, {!re.own_d, re.own_d});
          chk((re.own_d ? d_rdata : if_rdata) == re.data, $sformatf("L%0d_rdata", L),
              re.own_d ? d_rdata : if_rdata, re.data);
        end else begin
          chk({if_rvalid, d_rvalid} == 2'b0, $sformatf("L%0d_no_rvalid", L), {if_rvalid, d_rvalid}, 0);
        end
      end
    end

    initial begin
      int n;
      int tgt;
      resetn = 1'b0; if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      ast[0] = 0; ast[1] = 0;
      for (int i = 0; i < 512; i++) ram_wr[i] = 1'b0;

      // Both requesters busy straight out of reset: data wins the first tie, then strict alternation.
      rst_left = 3;
      for (int i = 0; i < 4; i++) begin
        iq_if.push_back('{0, 1'b0, 16'h0040 + 16'(i), 16'h0});
        iq_d.push_back('{0, 1'b0, 16'h0080 + 16'(i), 16'h0});
      end
      wait_idle(300, "alt");
      for (int i = 0; i < 8; i++)
        chk(olog.size() > i && olog[i] == ((i % 2) == 0), $sformatf("L%0d_alt_order%0d", L, i),
            (olog.size() > i) ? 32'(olog[i]) : 32'd2, 32'((i % 2) == 0));

      // Lone fetch of the known word, lone store, then a load of the stored word.
      iq_if.push_back('{2, 1'b0, 16'h0010, 16'h0});
      wait_idle(100, "fetch");
      iq_d.push_back('{2, 1'b1, 16'h0100, 16'h1234});
      iq_d.push_back('{1, 1'b0, 16'h0100, 16'h0});
      wait_idle(100, "store_load");

      // Random mixed traffic on a small shared address range.
      for (int i = 0; i < 40; i++) begin
        iq_if.push_back('{int'($urandom_range(0, 3)), 1'b0, 16'($urandom_range(0, 31)), 16'h0});
        iq_d.push_back('{int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         16'($urandom_range(0, 31)), 16'($urandom)});
      end
      wait_idle(4000, "random");

      // Reset while the read is outstanding (WAIT at latency 3, ISSUE at latency 1).
      iq_if.push_back('{0, 1'b0, 16'h0033, 16'h0});
      n = 0;
      while (gq.size() == 0 && n < 50) begin step(); n++; end
      chk(n < 50, $sformatf("L%0d_rst_setup_timeout", L), n, 50);
      tgt = (gq.size() > 0) ? gq[0].cyc + ((L > 1) ? 1 : 0) : cyc + 1;
      while (cyc < tgt - 1) step();
      rst_left = 2;
      step();
      step();
      iq_if.push_back('{0, 1'b0, 16'h0044, 16'h0});
      wait_idle(100, "post_reset");
      repeat (3) step();
      done_cnt++;
    end
  end

  initial begin
    int t = 0;
    while (done_cnt < 2 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk(done_cnt == 2, "global_timeout", done_cnt, 2);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port unified instruction/data memory of the 16-bit multicycle CPU. Shares the port between the instruction-fetch requester (driven in the fetch state) and the data requester (load/store memory states). Registers each winning request, issues it to memory, and returns read data with a one-cycle valid pulse after a fixed memory latency. Sits between `control_unit`/datapath and the memory macro.

## Interface
- `ADDR_WIDTH`, 16, memory word address width
- `DATA_WIDTH`, 16, memory word width
- `MEM_LATENCY`, 1, cycles from `mem_en` cycle to valid `mem_rdata`; legal range 1..4
- `clk`  in  1  clock, all state updates on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_gnt`  out  1  one-cycle pulse: fetch request issued to memory
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  DATA_WIDTH  fetch read data
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_WIDTH  data address
- `d_wdata`  in  DATA_WIDTH  store data
- `d_gnt`  out  1  one-cycle pulse: data request issued
- `d_rvalid`  out  1  one-cycle pulse, loads only
- `d_rdata`  out  DATA_WIDTH  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data

## Operation
- FSM states: `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`.
- `ARB_IDLE`:
  - With no request, stay in `ARB_IDLE`.
  - With any request, pick a winner and register its `we`/`addr`/`wdata` plus an owner bit, then go to `ARB_ISSUE`.
- Arbitration is round-robin on the `last_owner` bit:
  - When both request, the requester that was not served last wins.
  - After reset `last_owner` = fetch, so data wins the first tie.
  - A lone request always wins.
- `ARB_ISSUE`:
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the registered request.
  - The owner's `gnt` pulses; `last_owner` updates.
  - Store: go to `ARB_IDLE` next.
  - Load or fetch with `MEM_LATENCY`=1: go to `ARB_RESP`.
  - Load or fetch with `MEM_LATENCY`>1: go to `ARB_WAIT`, loading the counter with `MEM_LATENCY`-2.
- `ARB_WAIT`: decrement the counter; at 0 go to `ARB_RESP`. Counter width is `$clog2(MEM_LATENCY)`, minimum 1.
- `ARB_RESP`: the owner's `rvalid`=1, then go to `ARB_IDLE`.
- `if_rdata` and `d_rdata` are both driven combinationally from `mem_rdata`. They are only meaningful while the matching `rvalid` is high.
- Stores never produce `rvalid`.
- Requests are sampled only in `ARB_IDLE`. Input changes outside `ARB_IDLE` are ignored.
- The non-winning request stays pending and needs no re-assertion.
- A requester dropping `req` before its `gnt` is a protocol violation. The arbiter completes the already-captured access anyway.
- `mem_en`/`mem_we` are low in every state except `ARB_ISSUE`.

## Timing
- All outputs reset to 0; FSM resets to `ARB_IDLE`; `last_owner` resets to fetch.
- Request seen in `ARB_IDLE` at cycle N:
  - `gnt` and `mem_en` at N+1.
  - Read `rvalid` at N+1+`MEM_LATENCY`.
  - Next arbitration at N+2+`MEM_LATENCY` for reads, N+2 for stores.
- Throughput:
  - Read: one per `MEM_LATENCY`+2 cycles.
  - Store: one per 2 cycles.
- Reset asserted mid-operation:
  - The next edge returns to `ARB_IDLE`.
  - No pending `gnt`/`rvalid` is emitted.
  - `mem_en` is 0 from that edge on.
- Request asserted in the same cycle as `rvalid` (`ARB_RESP`) is not sampled until `ARB_IDLE`, one cycle later.

## Structure
- `defs_pkg`:
  - `arb_state_t` enum (4 states).
  - `arb_owner_t` enum (`OWNER_IF`, `OWNER_D`).
  - `mem_req_t` packed struct {we, addr, wdata}.
- Single module; no sub-module needed. Round-robin pick and latency counter stay inline.

## Test plan
- Lone fetch, `if_addr`=0x0010, `mem_rdata`=0xA5A5, `MEM_LATENCY`=1 -> `if_gnt` at N+1 with `mem_addr`=0x0010, `mem_we`=0; `if_rvalid` at N+2 with `if_rdata`=0xA5A5.
- Lone store, `d_addr`=0x0100, `d_wdata`=0x1234 -> `d_gnt` and `mem_en`/`mem_we`=1 at N+1 with matching addr/data; no `d_rvalid`; `ARB_IDLE` at N+2.
- Both request continuously from reset -> grants alternate D, IF, D, IF; each `rvalid` routed only to its owner.
- `MEM_LATENCY`=3 load, `d_addr`=0x0200 -> `d_gnt` at N+1, `d_rvalid` at N+4, next grant no earlier than N+6 (one cycle after `ARB_IDLE` at N+5).
- `resetn` low during `ARB_WAIT` -> no `rvalid` ever; all outputs 0 after the edge; a fresh `if_req` after release is granted normally.
- Data request raised while a fetch is in `ARB_WAIT` -> `d_gnt` exactly 2 cycles after `if_rvalid`; the captured fetch address is unaffected by `if_addr` changes during `ARB_WAIT`.
